// File: rtl/addsub_fu.sv
// addsub_fu: non-pipelined add/subtract functional unit sitting behind the
// add/sub reservation station. It captures one operation through the
// despacho/confirma handshake, computes the result over a fixed number of
// execute cycles, then requests the common data bus and broadcasts
// {tag, result} in the cycle the arbiter grants it.
module addsub_fu #(
    parameter int LATENCY = 2,   // execute cycles from capture to first cdb_req (1..7)
    parameter int DW      = 16   // operand/result width
) (
    input  logic          CLK,
    input  logic          CLR,        // asynchronous, active-low
    input  logic          despacho,
    input  logic [DW-1:0] Valor1,
    input  logic [DW-1:0] Valor2,
    input  logic [2:0]    OP,
    input  logic [2:0]    ID_in,
    output logic          confirma,
    output logic          busy,
    output logic          cdb_req,
    input  logic          cdb_grant,
    output logic [DW+2:0] CDB,
    output logic          err
);

    // Counter preload: the capture edge already accounts for one execute
    // cycle, so EXEC only needs LATENCY-1 further decrements before finishing.
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] TAG_NONE = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_WAIT_CDB = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [2:0]    op_q, op_d;
    logic [2:0]    tag_q, tag_d;
    logic [DW-1:0] result_q, result_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          confirma_q, confirma_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          cdb_req_q, cdb_req_d;

    logic [DW-1:0] alu_result;
    logic          bcast;
    logic [DW+2:0] bus_word;

    // ALU: works only on the latched operand copies, so the RS is free to
    // change its operand lines once confirma has been seen.
    always_comb begin
        if (op_q == OP_SUB) begin
            alu_result = opa_q - opb_q;
        end else begin
            alu_result = opa_q + opb_q;
        end
    end

    // Next-state and registered-output logic for the IDLE/EXEC/WAIT_CDB FSM.
    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        op_d       = op_q;
        tag_d      = tag_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        cdb_req_d  = cdb_req_q;
        confirma_d = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (despacho) begin
                    // Both a good and a reserved-tag dispatch are acknowledged
                    // so the RS never stalls on a malformed entry.
                    confirma_d = 1'b1;
                    if (ID_in == TAG_NONE) begin
                        err_d = 1'b1;
                    end else begin
                        opa_d   = Valor1;
                        opb_d   = Valor2;
                        op_d    = OP;
                        tag_d   = ID_in;
                        cnt_d   = CNT_INIT;
                        state_d = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                if (cnt_q == 3'd0) begin
                    result_d  = alu_result;
                    cdb_req_d = 1'b1;
                    state_d   = S_WAIT_CDB;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_WAIT_CDB: begin
                // The broadcast happens combinationally during the granted
                // cycle; this edge just retires the operation.
                if (cdb_grant) begin
                    cdb_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                cdb_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; CLR wipes everything, including any
    // operation in flight, so no broadcast follows a mid-operation reset.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q    <= S_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            confirma_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            cdb_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            confirma_q <= confirma_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            cdb_req_q  <= cdb_req_d;
        end
    end

    // A grant only counts while this unit is actually requesting; a stray
    // grant at any other time leaves the bus at zero.
    assign bcast    = cdb_req_q & cdb_grant & (state_q == S_WAIT_CDB);
    assign bus_word = {tag_q, result_q};

    // Per-bit AND gating keeps the bus all-zero whenever we are not driving it.
    generate
        for (genvar gi = 0; gi < DW + 3; gi++) begin : g_cdb_gate
            assign CDB[gi] = bus_word[gi] & bcast;
        end
    endgenerate

    assign confirma = confirma_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign cdb_req  = cdb_req_q;

endmodule
